// File: rtl/virtq_pkg.sv
// Shared constants and FSM state type for the virtqueue notify arbiter.
package virtq_pkg;
  localparam int VIRTQ_NUM_QUEUES = 3;
  localparam int VIRTQ_QID_W      = 2;
  localparam int VIRTQ_CNT_W      = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } virtq_state_e;
endpackage

// File: rtl/virtq_rr_pick.sv
// Combinational round-robin pick: first set bit of eligible at or after rr_ptr, wrapping.
module virtq_rr_pick #(
  parameter int NUM_QUEUES = 3,
  parameter int QID_W      = 2
) (
  input  logic [NUM_QUEUES-1:0] eligible,
  input  logic [QID_W-1:0]      rr_ptr,
  output logic                  found,
  output logic [QID_W-1:0]      index
);
  always_comb begin
    int j;
    found = 1'b0;
    index = '0;
    j     = 0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      // Explicit wrap keeps non-power-of-2 queue counts correct.
      j = int'(rr_ptr) + i;
      if (j >= NUM_QUEUES) j = j - NUM_QUEUES;
      if (!found && eligible[j]) begin
        found = 1'b1;
        index = QID_W'(j);
      end
    end
  end
endmodule

// File: rtl/virtq_notify_arbiter.sv
// Round-robin arbiter turning virtqueue notify pulses into one-at-a-time service offers.
// Optional per-queue coalesce counters are built when VIRTQ_NOTIFY_STATS_EN is defined.
module virtq_notify_arbiter
  import virtq_pkg::*;
#(
  parameter int NUM_QUEUES = VIRTQ_NUM_QUEUES,
  parameter int QID_W      = VIRTQ_QID_W,
  parameter int CNT_W      = VIRTQ_CNT_W
) (
  input  logic                        clk,
  input  logic                        csr_rst,
  input  logic [NUM_QUEUES-1:0]       notify_set,
  input  logic [NUM_QUEUES-1:0]       queue_enable,
  output logic                        req_valid,
  output logic [QID_W-1:0]            req_qid,
  input  logic                        req_ready,
  input  logic                        done_valid,
  input  logic [QID_W-1:0]            done_qid,
`ifdef VIRTQ_NOTIFY_STATS_EN
  output logic [NUM_QUEUES*CNT_W-1:0] coalesce_cnt,
  input  logic                        stats_clr,
`endif
  output logic [NUM_QUEUES-1:0]       pending,
  output logic [NUM_QUEUES-1:0]       busy
);
  if (NUM_QUEUES < 2 || NUM_QUEUES > 32 || (2 ** QID_W) < NUM_QUEUES || CNT_W < 1) begin : g_bad_param
    $error("virtq_notify_arbiter: illegal parameter combination");
  end

  virtq_state_e            state_q, state_d;
  logic [QID_W-1:0]        req_qid_q, req_qid_d;
  logic [QID_W-1:0]        rr_ptr_q, rr_ptr_d, pick_ptr, pick_idx;
  logic [NUM_QUEUES-1:0]   pending_q, pending_d, busy_q, busy_d;
  logic [NUM_QUEUES-1:0]   sel, hs_hit, done_hit, pick_mask;
  logic                    hs, kill, pick_found;

  assign req_valid = (state_q == OFFER);
  assign req_qid   = req_qid_q;
  assign pending   = pending_q;
  assign busy      = busy_q;

  assign hs   = req_valid & req_ready;
  // Offered queue lost its enable: withdraw the offer on this edge.
  assign kill = req_valid & ~|(sel & queue_enable);

  for (genvar q = 0; q < NUM_QUEUES; q++) begin : g_q
    assign sel[q]      = (req_qid_q == QID_W'(q));
    assign hs_hit[q]   = hs & sel[q];
    assign done_hit[q] = done_valid & (done_qid == QID_W'(q)) & busy_q[q];
    // A coincident done frees the queue for this cycle's pick; the granted queue is excluded.
    assign pick_mask[q] = pending_q[q] & queue_enable[q] & ~(busy_q[q] & ~done_hit[q]) & ~hs_hit[q];

    always_comb begin
      pending_d[q] = pending_q[q];
      busy_d[q]    = busy_q[q];
      if (!queue_enable[q]) begin
        pending_d[q] = 1'b0;
        busy_d[q]    = 1'b0;
      end else begin
        if (notify_set[q])   pending_d[q] = 1'b1;
        else if (hs_hit[q])  pending_d[q] = 1'b0;
        if (hs_hit[q])       busy_d[q] = 1'b1;
        else if (done_hit[q]) busy_d[q] = 1'b0;
      end
    end
  end

  assign pick_ptr = !hs ? rr_ptr_q :
                    (req_qid_q == QID_W'(NUM_QUEUES - 1)) ? '0 : req_qid_q + QID_W'(1);

  virtq_rr_pick #(
    .NUM_QUEUES (NUM_QUEUES),
    .QID_W      (QID_W)
  ) u_pick (
    .eligible (pick_mask),
    .rr_ptr   (pick_ptr),
    .found    (pick_found),
    .index    (pick_idx)
  );

  always_ff @(posedge clk or posedge csr_rst) begin
    if (csr_rst) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_found) state_d = OFFER;
      OFFER: begin
        if (kill)    state_d = IDLE;
        else if (hs) state_d = pick_found ? OFFER : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_qid_d = req_qid_q;
    rr_ptr_d  = rr_ptr_q;
    if (hs) rr_ptr_d = pick_ptr;
    if (state_d == OFFER && (state_q == IDLE || hs)) req_qid_d = pick_idx;
  end

  always_ff @(posedge clk or posedge csr_rst) begin
    if (csr_rst) begin
      req_qid_q <= '0;
      rr_ptr_q  <= '0;
      pending_q <= '0;
      busy_q    <= '0;
    end else begin
      req_qid_q <= req_qid_d;
      rr_ptr_q  <= rr_ptr_d;
      pending_q <= pending_d;
      busy_q    <= busy_d;
    end
  end

`ifdef VIRTQ_NOTIFY_STATS_EN
  logic [NUM_QUEUES-1:0][CNT_W-1:0] cnt_q;

  // Counts notifies absorbed into an already-pending flag; saturates.
  always_ff @(posedge clk or posedge csr_rst) begin
    if (csr_rst) begin
      cnt_q <= '0;
    end else if (stats_clr) begin
      cnt_q <= '0;
    end else begin
      for (int q = 0; q < NUM_QUEUES; q++)
        if (notify_set[q] && queue_enable[q] && pending_q[q] && !(&cnt_q[q]))
          cnt_q[q] <= cnt_q[q] + CNT_W'(1);
    end
  end

  assign coalesce_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_virtq_notify_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-level model.
module tb_virtq_notify_arbiter;
  localparam int N     = 3;
  localparam int QW    = 2;
  localparam int CW    = 2;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          csr_rst = 1'b1;
  logic [N-1:0]  notify_set = '0;
  logic [N-1:0]  queue_enable = '0;
  logic          req_valid;
  logic [QW-1:0] req_qid;
  logic          req_ready = 1'b0;
  logic          done_valid = 1'b0;
  logic [QW-1:0] done_qid = '0;
  logic [N-1:0]  pending, busy;
  logic          stats_clr = 1'b0;
  logic [N*CW-1:0] coalesce_cnt;

  int n_chk = 0;
  int n_err = 0;

  // Model state: plain per-queue flags and integers.
  bit m_pend[N];
  bit m_bsy[N];
  int m_cnt[N];
  int m_rr, m_oq;
  bit m_off;

  always #5 clk = ~clk;

  virtq_notify_arbiter #(.NUM_QUEUES(N), .QID_W(QW), .CNT_W(CW)) dut (
    .clk          (clk),
    .csr_rst      (csr_rst),
    .notify_set   (notify_set),
    .queue_enable (queue_enable),
    .req_valid    (req_valid),
    .req_qid      (req_qid),
    .req_ready    (req_ready),
    .done_valid   (done_valid),
    .done_qid     (done_qid),
`ifdef VIRTQ_NOTIFY_STATS_EN
    .coalesce_cnt (coalesce_cnt),
    .stats_clr    (stats_clr),
`endif
    .pending      (pending),
    .busy         (busy)
  );
`ifndef VIRTQ_NOTIFY_STATS_EN
  assign coalesce_cnt = '0;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [31:0] vec(input bit a[N]);
    logic [31:0] v = '0;
    for (int q = 0; q < N; q++) v[q] = a[q];
    return v;
  endfunction

  task automatic model_reset();
    for (int q = 0; q < N; q++) begin m_pend[q] = 0; m_bsy[q] = 0; m_cnt[q] = 0; end
    m_rr = 0; m_oq = 0; m_off = 0;
  endtask

  // One clock edge of the specified behaviour, using the inputs present before the edge.
  task automatic model_step();
    bit hs, kill, found, dn, en;
    bit elig[N];
    bit np[N], nb[N];
    int ptr, idx, c;
    hs    = m_off && req_ready;
    kill  = m_off && !queue_enable[m_oq];
    ptr   = hs ? (m_oq + 1) % N : m_rr;
    found = 0; idx = 0;
    for (int q = 0; q < N; q++) begin
      en = queue_enable[q];
      dn = done_valid && (int'(done_qid) == q) && m_bsy[q];
      elig[q] = m_pend[q] && en && (!m_bsy[q] || dn) && !(hs && q == m_oq);
      np[q] = !en ? 0 : notify_set[q] ? 1 : (hs && q == m_oq) ? 0 : m_pend[q];
      nb[q] = !en ? 0 : (hs && q == m_oq) ? 1 : dn ? 0 : m_bsy[q];
      if (stats_clr) m_cnt[q] = 0;
      else if (notify_set[q] && en && m_pend[q] && m_cnt[q] < CMAX) m_cnt[q]++;
    end
    for (int k = 0; k < N; k++) begin
      c = (ptr + k) % N;
      if (!found && elig[c]) begin found = 1; idx = c; end
    end
    if (hs) m_rr = (m_oq + 1) % N;
    if (!m_off) begin
      if (found) begin m_off = 1; m_oq = idx; end
    end else if (kill) m_off = 0;
    else if (hs) begin
      m_off = found;
      if (found) m_oq = idx;
    end
    for (int q = 0; q < N; q++) begin m_pend[q] = np[q]; m_bsy[q] = nb[q]; end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".req_valid"}, 32'(req_valid), 32'(m_off));
    chk({tag, ".req_qid"},   32'(req_qid),   32'(m_oq));
    chk({tag, ".pending"},   32'(pending),   vec(m_pend));
    chk({tag, ".busy"},      32'(busy),      vec(m_bsy));
`ifdef VIRTQ_NOTIFY_STATS_EN
    for (int q = 0; q < N; q++)
      chk({tag, ".cnt"}, 32'((coalesce_cnt >> (q * CW)) & CMAX), 32'(m_cnt[q]));
`endif
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic [N-1:0] ns, input logic rdy, input logic dv, input logic [QW-1:0] dq);
    notify_set = ns; req_ready = rdy; done_valid = dv; done_qid = dq;
  endtask

  task automatic do_reset();
    #2;
    csr_rst = 1'b1;
    #1;
    model_reset();
    check_all("rst");
    chk("rst.valid_zero", 32'(req_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    csr_rst = 1'b0;
  endtask

  initial begin
    queue_enable = '1;
    do_reset();

    // Single notify: pending next cycle, offer the cycle after.
    drive(3'b010, 0, 0, 0); tick("lat1");
    chk("lat.pending", 32'(pending), 32'b010);
    chk("lat.valid_n1", 32'(req_valid), 32'd0);
    drive(3'b000, 0, 0, 0); tick("lat2");
    chk("lat.valid_n2", 32'(req_valid), 32'd1);
    chk("lat.qid", 32'(req_qid), 32'd1);
    drive(3'b000, 1, 0, 0); tick("lat3");
    chk("lat.busy", 32'(busy), 32'b010);
    drive(3'b000, 0, 1, 1); tick("lat4");

    // Burst: consecutive grants 0,1,2.
    do_reset();
    drive(3'b111, 1, 0, 0); tick("burst0");
    drive(3'b000, 1, 0, 0);
    for (int g = 0; g < N; g++) begin
      tick("burst");
      chk("burst.valid", 32'(req_valid), 32'd1);
      chk("burst.qid", 32'(req_qid), 32'(g));
    end
    tick("burst_end");
    chk("burst.busy", 32'(busy), 32'b111);
    chk("burst.idle", 32'(req_valid), 32'd0);

    // Wrap: after queue 2, re-notify all -> 0,1,2 again.
    for (int q = 0; q < N; q++) begin drive(3'b000, 1, 1, QW'(q)); tick("wrap_done"); end
    chk("wrap.busy_clear", 32'(busy), 32'd0);
    drive(3'b111, 1, 0, 0); tick("wrap0");
    drive(3'b000, 1, 0, 0);
    for (int g = 0; g < N; g++) begin
      tick("wrap");
      chk("wrap.qid", 32'(req_qid), 32'(g));
    end
    tick("wrap_end");

    // Notify while busy, then done: re-offered right after done.
    drive(3'b001, 0, 0, 0); tick("reoff0");
    chk("reoff.pending", 32'(pending), 32'b001);
    chk("reoff.no_offer", 32'(req_valid), 32'd0);
    drive(3'b000, 0, 1, 0); tick("reoff1");
    chk("reoff.valid", 32'(req_valid), 32'd1);
    chk("reoff.qid", 32'(req_qid), 32'd0);
    drive(3'b000, 1, 0, 0); tick("reoff2");
    for (int q = 0; q < N; q++) begin drive(3'b000, 0, 1, QW'(q)); tick("reoff_done"); end
    // Out-of-range and non-busy done are ignored.
    drive(3'b000, 0, 1, 2'd3); tick("done_oor");

    // Disable during offer.
    drive(3'b010, 0, 0, 0); tick("dis0");
    drive(3'b000, 0, 0, 0); tick("dis1");
    chk("dis.offer_qid", 32'(req_qid), 32'd1);
    queue_enable = 3'b101; tick("dis2");
    chk("dis.valid", 32'(req_valid), 32'd0);
    chk("dis.pending1", 32'(pending[1]), 32'd0);
    chk("dis.busy1", 32'(busy[1]), 32'd0);
    queue_enable = '1;

`ifdef VIRTQ_NOTIFY_STATS_EN
    drive(3'b001, 0, 0, 0); tick("cnt0");
    for (int p = 0; p < 5; p++) tick("cnt");
    chk("cnt.sat", 32'(coalesce_cnt[CW-1:0]), 32'd3);
    drive(3'b000, 0, 0, 0); stats_clr = 1'b1; tick("cnt_clr");
    chk("cnt.clr", 32'(coalesce_cnt[CW-1:0]), 32'd0);
    drive(3'b001, 0, 0, 0); tick("cnt_prio");
    chk("cnt.clr_prio", 32'(coalesce_cnt[CW-1:0]), 32'd0);
    stats_clr = 1'b0;
`endif

    // Reset mid-offer drops the offer.
    drive(3'b100, 0, 0, 0); tick("mid0");
    drive(3'b000, 0, 0, 0); tick("mid1");
    do_reset();
    chk("mid.pending", 32'(pending), 32'd0);
    tick("mid_post");
    chk("mid.idle", 32'(req_valid), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      notify_set   = N'($urandom & $urandom);
      req_ready    = ($urandom_range(0, 2) != 0);
      done_valid   = ($urandom_range(0, 1) != 0);
      done_qid     = QW'($urandom_range(0, 3));
      queue_enable = ($urandom_range(0, 15) == 0) ? N'($urandom) : '1;
      stats_clr    = ($urandom_range(0, 63) == 0);
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/virtq_notify_arbiter.md
VIRTQ_NOTIFY_ARBITER -- requirements
Module: virtq_notify_arbiter

Interface
REQ-001 SHALL have parameter NUM_QUEUES, default 3: number of virtqueues tracked; legal range 2..32.
REQ-002 SHALL have parameter QID_W, default 2: queue-index width; SHALL satisfy 2**QID_W >= NUM_QUEUES.
REQ-003 SHALL have parameter CNT_W, default 8: width of each per-queue coalesce counter.
REQ-004 SHALL have the following ports, one per line as name, direction, width, meaning:
- clk  input  1  sole clock; all state on its rising edge.
- csr_rst  input  1  reset, asynchronous, active-high.
- notify_set  input  NUM_QUEUES  one-cycle pulse per queue on a queue_notify CSR write.
- queue_enable  input  NUM_QUEUES  per-queue queue_ready level.
- req_valid  output  1  a pending queue is offered for service.
- req_qid  output  QID_W  index of the offered queue.
- req_ready  input  1  consumer accepts the offer.
- done_valid  input  1  consumer finished servicing a queue.
- done_qid  input  QID_W  queue being completed.
- pending  output  NUM_QUEUES  per-queue pending-notify flags.
- busy  output  NUM_QUEUES  per-queue in-service flags.
- coalesce_cnt  output  NUM_QUEUES*CNT_W  per-queue counters, queue q at bits [q*CNT_W +: CNT_W]; present only with VIRTQ_NOTIFY_STATS_EN.
- stats_clr  input  1  synchronous clear of all coalesce_cnt; present only with VIRTQ_NOTIFY_STATS_EN.

Function
REQ-005 SHALL set pending[q] on the edge after notify_set[q]=1 when queue_enable[q]=1; SHALL ignore notify_set[q] when queue_enable[q]=0.
REQ-006 SHALL treat queue q as eligible when pending[q] & ~busy[q] & queue_enable[q].
REQ-007 SHALL implement a 2-state FSM: IDLE (req_valid=0) and OFFER (req_valid=1).
REQ-008 IDLE->OFFER SHALL occur when any queue is eligible; req_qid SHALL be the first eligible queue at or after rr_ptr, searching upward and wrapping from NUM_QUEUES-1 to 0.
REQ-009 Minimum latency SHALL be notify_set in cycle N, pending=1 in cycle N+1, req_valid=1 in cycle N+2; all outputs SHALL be registered.
REQ-010 In OFFER, req_qid SHALL be held stable until req_valid & req_ready; the only exception is REQ-014.
REQ-011 On handshake for queue q: pending[q] SHALL clear, busy[q] SHALL set, and rr_ptr SHALL become (q+1) mod NUM_QUEUES, wrapping correctly for non-power-of-2 NUM_QUEUES.
REQ-012 After a handshake, if another queue is eligible, the FSM SHALL stay in OFFER with the new req_qid on the next cycle (one grant per cycle); otherwise it SHALL return to IDLE.
REQ-013 notify_set[q] coincident with the handshake of q SHALL leave pending[q]=1 (set wins). notify_set[q] while busy[q]=1 SHALL set pending[q] so that q is re-serviced after done.
REQ-014 queue_enable[q] falling SHALL clear pending[q] and busy[q] on the next edge; if q is being offered, req_valid SHALL drop on that same edge.
REQ-015 done_valid with busy[done_qid]=1 SHALL clear busy[done_qid]; done for a non-busy queue, or with done_qid >= NUM_QUEUES, SHALL be ignored.
REQ-016 done_valid for q coincident with the handshake of a different queue SHALL apply both updates.

Reset
REQ-017 csr_rst=1 SHALL asynchronously force: FSM to IDLE, req_valid=0, req_qid=0, pending=0, busy=0, rr_ptr=0, coalesce_cnt=0.
REQ-018 Reset asserted mid-offer SHALL drop the offer with no handshake recorded; state after release SHALL equal post-reset state.

Configuration
REQ-019 With VIRTQ_NOTIFY_STATS_EN defined:
- coalesce_cnt[q] SHALL increment when notify_set[q]=1 while pending[q]=1 already, saturating at all-ones.
- stats_clr SHALL zero all counters; stats_clr SHALL take priority over a coincident increment.
REQ-020 Without VIRTQ_NOTIFY_STATS_EN, the coalesce_cnt and stats_clr ports and the counter logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-021 The shared package virtq_pkg SHALL hold the default NUM_QUEUES, QID_W and CNT_W constants and the FSM state typedef {IDLE, OFFER}.
REQ-022 The round-robin search SHALL be the sub-module virtq_rr_pick: combinational; inputs eligible mask and rr_ptr; outputs found and index.

Verification
REQ-023 Single pulse notify_set=3'b010 in cycle 10 -> pending[1] high in cycle 11; req_valid with req_qid=1 in cycle 12.
REQ-024 notify_set=3'b111 in one cycle, req_ready held at 1 -> grants 0, 1, 2 in consecutive cycles; busy=3'b111.
REQ-025 Queue 2 granted, then all queues re-notified after done for all three -> next grant order is 0, 1, 2 (rr_ptr wraps from 2 to 0).
REQ-026 notify_set[0] during busy[0], then done_qid=0 -> queue 0 is re-offered 1 cycle after done.
REQ-027 Offer of queue 1 with req_ready=0, then queue_enable[1] dropped -> req_valid=0 on the next edge; pending[1]=0 and busy[1]=0.
REQ-028 With VIRTQ_NOTIFY_STATS_EN and CNT_W=2, five notify_set[0] pulses while pending[0]=1 -> coalesce_cnt[0]=3 (saturated); stats_clr -> 0.
